leakage_window_accumulator: RTL and testbench

- Downstream consumer of the data converter's 4-bit Hamming-weight/distance output (hamming_sum, range 0..8).
- Accumulates per-window leakage statistics over WINDOW accepted samples: sum, sum of squares, min and max.
- Presents each completed window's results through a one-entry valid/ready output buffer to the trace/CPA logic further downstream.

---
 rtl/leakage_window_accumulator.sv | 152 +++++++++++++++
 tb/tb_leakage_window_accumulator.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/leakage_window_accumulator.sv
// Per-window leakage statistics (sum, sum of squares, min, max) over WINDOW accepted
// Hamming samples, presented through a one-entry valid/ready result buffer.
module leakage_window_accumulator #(
    parameter int WINDOW = 256,
    parameter int CNT_W  = 8,
    parameter int WCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              sample_valid,
    input  logic [3:0]        hamming_sum,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W+3:0]  win_sum,
    output logic [CNT_W+6:0]  win_sumsq,
    output logic [3:0]        win_min,
    output logic [3:0]        win_max,
    output logic [WCNT_W-1:0] win_count,
    output logic              overrun,
    output logic              range_err
);

    localparam logic [0:0]       ST_IDLE  = 1'b0;
    localparam logic [0:0]       ST_ACCUM = 1'b1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WINDOW - 1);

    logic [0:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W+3:0]  sum_q, sum_d, sum_add_s;
    logic [CNT_W+6:0]  sumsq_q, sumsq_d, sumsq_add_s;
    logic [3:0]        min_q, min_d, min_upd_s;
    logic [3:0]        max_q, max_d, max_upd_s;
    logic [7:0]        sample_sq_s;
    logic              accept_s, complete_s, load_s;

    logic              out_valid_q, out_valid_d;
    logic [CNT_W+3:0]  win_sum_q, win_sum_d;
    logic [CNT_W+6:0]  win_sumsq_q, win_sumsq_d;
    logic [3:0]        win_min_q, win_min_d;
    logic [3:0]        win_max_q, win_max_d;
    logic [WCNT_W-1:0] win_count_q, win_count_d;
    logic              overrun_q, overrun_d;
    logic              range_err_q, range_err_d;

    // Sample qualification and the running statistics including the current sample
    always_comb begin
        accept_s    = run && sample_valid && (hamming_sum <= 4'd8);
        sample_sq_s = {4'd0, hamming_sum} * {4'd0, hamming_sum};
        sum_add_s   = sum_q + {{CNT_W{1'b0}}, hamming_sum};
        sumsq_add_s = sumsq_q + {{(CNT_W-1){1'b0}}, sample_sq_s};
        min_upd_s   = (hamming_sum < min_q) ? hamming_sum : min_q;
        max_upd_s   = (hamming_sum > max_q) ? hamming_sum : max_q;
        // In IDLE the counter is zero and WINDOW >= 2, so completion only happens in ACCUM
        complete_s  = accept_s && (state_q == ST_ACCUM) && (cnt_q == LAST_IDX);
        load_s      = complete_s && (!out_valid_q || out_ready);
    end

    // Window state machine and accumulators
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        sumsq_d = sumsq_q;
        min_d   = min_q;
        max_d   = max_q;
        if (!run || complete_s) begin
            state_d = run ? ST_ACCUM : ST_IDLE;
            cnt_d   = {CNT_W{1'b0}};
            sum_d   = {(CNT_W+4){1'b0}};
            sumsq_d = {(CNT_W+7){1'b0}};
            min_d   = 4'd15;
            max_d   = 4'd0;
        end else if (accept_s) begin
            state_d = ST_ACCUM;
            cnt_d   = cnt_q + CNT_W'(1);
            sum_d   = sum_add_s;
            sumsq_d = sumsq_add_s;
            min_d   = min_upd_s;
            max_d   = max_upd_s;
        end else begin
            state_d = state_q;
        end
    end

    // Result buffer, window counter and sticky error flags
    always_comb begin
        win_sum_d   = win_sum_q;
        win_sumsq_d = win_sumsq_q;
        win_min_d   = win_min_q;
        win_max_d   = win_max_q;
        if (load_s) begin
            out_valid_d = 1'b1;
            win_sum_d   = sum_add_s;
            win_sumsq_d = sumsq_add_s;
            win_min_d   = min_upd_s;
            win_max_d   = max_upd_s;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
        win_count_d = complete_s ? (win_count_q + WCNT_W'(1)) : win_count_q;
        overrun_d   = overrun_q || (complete_s && out_valid_q && !out_ready);
        range_err_d = range_err_q || (run && sample_valid && (hamming_sum > 4'd8));
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            sum_q       <= {(CNT_W+4){1'b0}};
            sumsq_q     <= {(CNT_W+7){1'b0}};
            min_q       <= 4'd15;
            max_q       <= 4'd0;
            out_valid_q <= 1'b0;
            win_sum_q   <= {(CNT_W+4){1'b0}};
            win_sumsq_q <= {(CNT_W+7){1'b0}};
            win_min_q   <= 4'd0;
            win_max_q   <= 4'd0;
            win_count_q <= {WCNT_W{1'b0}};
            overrun_q   <= 1'b0;
            range_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            sumsq_q     <= sumsq_d;
            min_q       <= min_d;
            max_q       <= max_d;
            out_valid_q <= out_valid_d;
            win_sum_q   <= win_sum_d;
            win_sumsq_q <= win_sumsq_d;
            win_min_q   <= win_min_d;
            win_max_q   <= win_max_d;
            win_count_q <= win_count_d;
            overrun_q   <= overrun_d;
            range_err_q <= range_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign win_sum   = win_sum_q;
    assign win_sumsq = win_sumsq_q;
    assign win_min   = win_min_q;
    assign win_max   = win_max_q;
    assign win_count = win_count_q;
    assign overrun   = overrun_q;
    assign range_err = range_err_q;

endmodule

// File: tb/tb_leakage_window_accumulator.sv
// Scoreboard bench for leakage_window_accumulator with WINDOW=4: a behavioural model
// predicts each loaded window and the per-cycle flags.
module tb_leakage_window_accumulator;

    localparam int WINDOW = 4;
    localparam int CNT_W  = 8;
    localparam int WCNT_W = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              run = 1'b0;
    logic              sample_valid = 1'b0;
    logic [3:0]        hamming_sum = 4'd0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [CNT_W+3:0]  win_sum;
    logic [CNT_W+6:0]  win_sumsq;
    logic [3:0]        win_min;
    logic [3:0]        win_max;
    logic [WCNT_W-1:0] win_count;
    logic              overrun;
    logic              range_err;

    leakage_window_accumulator #(.WINDOW(WINDOW), .CNT_W(CNT_W), .WCNT_W(WCNT_W)) dut (
        .clk(clk), .rst(rst), .run(run), .sample_valid(sample_valid),
        .hamming_sum(hamming_sum), .out_valid(out_valid), .out_ready(out_ready),
        .win_sum(win_sum), .win_sumsq(win_sumsq), .win_min(win_min), .win_max(win_max),
        .win_count(win_count), .overrun(overrun), .range_err(range_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int s;
        int q;
        int mn;
        int mx;
        int wc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    // Model state
    int m_cnt, m_sum, m_sq, m_min, m_max, m_wc;
    bit m_full, m_ovr, m_rerr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic model_clear();
        m_cnt = 0; m_sum = 0; m_sq = 0; m_min = 15; m_max = 0;
        m_wc = 0; m_full = 1'b0; m_ovr = 1'b0; m_rerr = 1'b0;
        exp_q.delete();
    endtask

    // One clock: predict the next state, take the edge, then compare
    task automatic step();
        bit   acc, loaded, fresh_ok;
        exp_t e;
        fresh_ok = !out_valid || out_ready;
        loaded = 1'b0;
        acc = run && sample_valid && (hamming_sum <= 4'd8);
        if (run && sample_valid && hamming_sum > 4'd8) m_rerr = 1'b1;
        if (!run) begin
            m_cnt = 0; m_sum = 0; m_sq = 0; m_min = 15; m_max = 0;
        end else if (acc) begin
            m_sum += int'(hamming_sum);
            m_sq  += int'(hamming_sum) * int'(hamming_sum);
            if (int'(hamming_sum) < m_min) m_min = int'(hamming_sum);
            if (int'(hamming_sum) > m_max) m_max = int'(hamming_sum);
            m_cnt++;
            if (m_cnt == WINDOW) begin
                m_wc = (m_wc + 1) % 65536;
                if (!m_full || out_ready) begin
                    e.s = m_sum; e.q = m_sq; e.mn = m_min; e.mx = m_max; e.wc = m_wc;
                    exp_q.push_back(e);
                    loaded = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
                m_cnt = 0; m_sum = 0; m_sq = 0; m_min = 15; m_max = 0;
            end
        end
        if (loaded) m_full = 1'b1;
        else if (m_full && out_ready) m_full = 1'b0;

        @(posedge clk);
        #1;
        check("out_valid", 32'(out_valid), 32'(m_full));
        check("overrun", 32'(overrun), 32'(m_ovr));
        check("range_err", 32'(range_err), 32'(m_rerr));
        check("win_count", 32'(win_count), 32'(m_wc));
        if (out_valid && fresh_ok) begin
            if (exp_q.size() == 0) begin
                check("unexpected_window", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("win_sum", 32'(win_sum), 32'(e.s));
                check("win_sumsq", 32'(win_sumsq), 32'(e.q));
                check("win_min", 32'(win_min), 32'(e.mn));
                check("win_max", 32'(win_max), 32'(e.mx));
                check("win_count_at_load", 32'(win_count), 32'(e.wc));
            end
        end
    endtask

    task automatic smp(input logic [3:0] v);
        sample_valid = 1'b1;
        hamming_sum  = v;
        step();
        sample_valid = 1'b0;
    endtask

    task automatic idle();
        sample_valid = 1'b0;
        step();
    endtask

    // Asynchronous reset: outputs are checked before any clock edge occurs
    task automatic do_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_win_sum"}, 32'(win_sum), 32'd0);
        check({tag, "_win_sumsq"}, 32'(win_sumsq), 32'd0);
        check({tag, "_win_min"}, 32'(win_min), 32'd0);
        check({tag, "_win_max"}, 32'(win_max), 32'd0);
        check({tag, "_win_count"}, 32'(win_count), 32'd0);
        check({tag, "_overrun"}, 32'(overrun), 32'd0);
        check({tag, "_range_err"}, 32'(range_err), 32'd0);
        model_clear();
        run = 1'b0;
        sample_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        model_clear();
        do_reset("por");

        // Basic window with ready held high
        run = 1'b1; out_ready = 1'b1;
        smp(4'd1); smp(4'd2); smp(4'd3); smp(4'd4);
        idle();

        // Extremes with gaps between samples
        smp(4'd8); idle(); smp(4'd0); idle(); smp(4'd8); idle(); smp(4'd0);
        idle(); idle();

        // Out-of-range sample mid-window
        smp(4'd1); smp(4'd9); smp(4'd2); smp(4'd3); smp(4'd4);
        idle();

        // Completion coinciding with a transfer reloads the buffer without overrun
        out_ready = 1'b0;
        smp(4'd1); smp(4'd1); smp(4'd1); smp(4'd1);
        smp(4'd2); smp(4'd2); smp(4'd2);
        out_ready = 1'b1;
        smp(4'd2);
        check("reload_sum", 32'(win_sum), 32'd8);
        idle(); idle();

        // Overrun with back-to-back windows and a stalled consumer
        do_reset("rst2");
        run = 1'b1; out_ready = 1'b0;
        smp(4'd2); smp(4'd8); smp(4'd8); smp(4'd8);
        smp(4'd5); smp(4'd5); smp(4'd5); smp(4'd5);
        idle();
        check("ovr_hold_sum", 32'(win_sum), 32'd26);
        check("ovr_flag", 32'(overrun), 32'd1);
        check("ovr_count", 32'(win_count), 32'd2);
        out_ready = 1'b1;
        idle();
        check("ovr_drained", 32'(out_valid), 32'd0);

        // Partial window discarded when run drops
        do_reset("rst3");
        run = 1'b1; out_ready = 1'b1;
        smp(4'd3); smp(4'd3); smp(4'd3);
        run = 1'b0; idle(); idle();
        run = 1'b1;
        smp(4'd1); smp(4'd1); smp(4'd1); smp(4'd1);
        check("run_drop_sum", 32'(win_sum), 32'd4);
        check("run_drop_count", 32'(win_count), 32'd1);
        idle();

        // Asynchronous reset mid-window
        smp(4'd7); smp(4'd6);
        do_reset("rst_midwin");

        // Asynchronous reset while a window is presented and being accepted
        run = 1'b1; out_ready = 1'b1;
        smp(4'd3); smp(4'd4); smp(4'd5); smp(4'd6);
        do_reset("rst_midxfer");

        // Recovery window after reset
        run = 1'b1; out_ready = 1'b1;
        smp(4'd6); smp(4'd7); smp(4'd0); smp(4'd5);
        check("post_rst_sum", 32'(win_sum), 32'd18);
        idle(); idle();

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
